seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream consumer of the 28-bit segment word latched by the Avalon segment register
//  (4 digits x 7 segments). Time-multiplexes the four digits onto one shared segment bus.
//  Inserts per-slot blanking (anti-ghosting) and 4-bit PWM brightness.
//  Double-buffers the input word so a bus write never tears a displayed frame.
// PARAMETERS
//  DIGIT_TICKS     256  clk cycles per digit slot; multiple of 16, >= 32
//  DEADTIME_TICKS  16   blanked cycles at the start of each slot; < DIGIT_TICKS - 16
//  SEG_ACTIVE_LOW  1    1: a lit segment drives 0
//  DIG_ACTIVE_LOW  1    1: the enabled digit drives 0
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high
//  seg_data     in   28  live segment word; digit d = seg_data[7d+6:7d], bit0=a .. bit6=g
//  brightness   in   4   0 = dark, 15 = full on, n = n/16 duty within the lit window
//  seg_out      out  7   shared segment lines, a..g, polarity per SEG_ACTIVE_LOW
//  dig_out      out  4   digit enables, one-hot or none, polarity per DIG_ACTIVE_LOW
//  frame_start  out  1   one-cycle pulse when the shadow registers load
// BEHAVIOUR
//  - State: slot_cnt (0..DIGIT_TICKS-1), dig_idx (0..3), shadow_seg[27:0], shadow_bri[3:0].
//  - slot_cnt increments every cycle and wraps to 0.
//    On wrap, dig_idx increments modulo 4 (3 -> 0).
//  - Frame boundary = (slot_cnt==0 && dig_idx==0):
//    - shadow_seg <= seg_data; shadow_bri <= brightness;
//    - frame_start = 1 (combinational decode of the current state, no latency).
//  - lit = (slot_cnt >= DEADTIME_TICKS) && (shadow_bri==15 || slot_cnt[3:0] < shadow_bri).
//  - Outputs are registered; they reflect the state of the previous cycle (1-cycle latency):
//    - lit:     dig_out[dig_idx] active, others inactive;
//               seg_out = shadow_seg[7*dig_idx +: 7] with polarity applied.
//    - not lit: all dig_out inactive, seg_out all inactive.
//  - The segment bus never changes while any digit is active.
//    Segment and digit change only inside the blanking window.
//  - seg_data/brightness changes mid-frame are ignored until the next frame boundary.
//  - Simultaneous upstream write and frame boundary: the value present in that cycle
//    is captured. A write landing exactly on the boundary is captured; one cycle later
//    it waits a full frame.
//  - Reset (async, any time):
//    - slot_cnt=0, dig_idx=0, shadow_seg=0, shadow_bri=0;
//    - seg_out and dig_out all inactive (SEG/DIG_ACTIVE_LOW=1 -> 7'h7F / 4'hF);
//    - frame_start=0 while reset is asserted.
//    - First clock after release is a frame boundary: frame_start=1, shadow loads.
//  - Frame period = 4*DIGIT_TICKS cycles; frame_start period is exact, with no drift.
//  - brightness=0: display permanently dark; counters keep running, frame_start keeps pulsing.
// STRUCTURE
//  - Package seg7_pkg:
//    - NUM_DIGITS=4, SEG_W=7, WORD_W=28;
//    - segment index constants SEG_A..SEG_G (0..6);
//    - function seg_slice(word, idx) returning 7 bits.
//  - Sub-module seg7_slot_timer: slot_cnt/dig_idx counters; emits frame_boundary and in_dead.
//    Top level holds the shadow registers, PWM gate and output registers.
//  - Static assertions on the parameter constraints listed above.
// TESTING (DIGIT_TICKS=32, DEADTIME_TICKS=8, active-low)
//  1 reset held, then released -> seg_out=7F, dig_out=F during reset;
//    frame_start=1 on the 1st cycle after release, then every 128 cycles.
//  2 seg_data=0x0000_00_3F-style word with digit0=0x3F, digit1..3=0; brightness=15 ->
//    cycles 9..32 of slot 0: dig_out=E, seg_out=0x40;
//    cycles 1..8 of every slot: dig_out=F.
//  3 brightness=4 ->
//    per slot, lit only where slot_cnt>=8 and slot_cnt[3:0]<4, i.e. slot_cnt 16..19;
//    all else dark.
//  4 seg_data changed at frame cycle 40 -> displayed digits unchanged until next frame_start;
//    new value shown from the following frame.
//  5 reset asserted mid-slot while dig_out=B -> outputs inactive within the same cycle;
//    restart at digit 0 after release.
//  6 brightness=0, seg_data=all 1s, run 3 frames ->
//    dig_out stays F throughout; frame_start counts 3.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 4-digit, 7-segment scan driver.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;
    localparam int WORD_W     = NUM_DIGITS * SEG_W;

    // Segment bit positions inside one digit slice (a is bit 0, g is bit 6).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [SEG_W-1:0]  seg_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [1:0]        dig_idx_t;

    // Pick the 7 segment bits of digit idx out of the packed 28-bit word.
    function automatic seg_t seg_slice(input word_t word, input dig_idx_t idx);
        seg_t s;
        case (idx)
            2'd0:    s = word[SEG_W*0 +: SEG_W];
            2'd1:    s = word[SEG_W*1 +: SEG_W];
            2'd2:    s = word[SEG_W*2 +: SEG_W];
            default: s = word[SEG_W*3 +: SEG_W];
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot and digit counters for the scan driver. Each digit owns DIGIT_TICKS
// cycles; the first DEADTIME_TICKS of every slot are reported as dead time.
// The frame boundary is the first cycle of digit 0's slot.
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS    = 256,
    parameter int DEADTIME_TICKS = 16
) (
    input  logic     clk,
    input  logic     reset,
    output logic [3:0] pwm_phase_o,
    output dig_idx_t dig_idx_o,
    output logic     frame_boundary_o,
    output logic     in_dead_o
);

    localparam int CNT_W = $clog2(DIGIT_TICKS);

    // Parameter sanity: PWM needs whole 16-cycle periods, and the dead time
    // must leave at least one full PWM period of lit window in every slot.
    if ((DIGIT_TICKS % 16) != 0) begin : g_bad_ticks_mult
        $error("DIGIT_TICKS must be a multiple of 16");
    end
    if (DIGIT_TICKS < 32) begin : g_bad_ticks_min
        $error("DIGIT_TICKS must be at least 32");
    end
    if (DEADTIME_TICKS >= DIGIT_TICKS - 16) begin : g_bad_dead
        $error("DEADTIME_TICKS must be below DIGIT_TICKS - 16");
    end
    if (DEADTIME_TICKS < 0) begin : g_bad_dead_neg
        $error("DEADTIME_TICKS must not be negative");
    end

    logic [CNT_W-1:0] slot_cnt_q;
    logic [CNT_W-1:0] slot_cnt_d;
    dig_idx_t         dig_idx_q;
    dig_idx_t         dig_idx_d;
    logic             slot_wrap;

    // Next-state: slot counter wraps at DIGIT_TICKS-1 and advances the digit.
    always_comb begin
        slot_wrap  = (slot_cnt_q == CNT_W'(DIGIT_TICKS - 1));
        slot_cnt_d = slot_cnt_q + CNT_W'(1);
        dig_idx_d  = dig_idx_q;
        if (slot_wrap) begin
            slot_cnt_d = '0;
            dig_idx_d  = dig_idx_q + 2'd1;
        end
    end

    // Counter registers; reset parks the scan at the frame boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_q <= '0;
            dig_idx_q  <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            dig_idx_q  <= dig_idx_d;
        end
    end

    // Decodes of the current counter state, no added latency.
    always_comb begin
        pwm_phase_o      = slot_cnt_q[3:0];
        dig_idx_o        = dig_idx_q;
        frame_boundary_o = (slot_cnt_q == '0) && (dig_idx_q == 2'd0);
        in_dead_o        = (slot_cnt_q < CNT_W'(DEADTIME_TICKS));
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with per-slot blanking and
// 4-bit PWM brightness. The segment word and brightness are captured into
// shadow registers only at the frame boundary, so a mid-frame bus write
// never tears the displayed frame. Outputs are registered (1-cycle latency).
// Segment and digit lines are updated from the same register stage and
// both go inactive whenever the slot is not lit, so the segment bus only
// changes while every digit is off.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS    = 256,
    parameter int DEADTIME_TICKS = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] seg_data,
    input  logic [3:0]        brightness,
    output logic [SEG_W-1:0]  seg_out,
    output logic [3:0]        dig_out,
    output logic              frame_start
);

    localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic [3:0]       DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [3:0]  pwm_phase;
    dig_idx_t    dig_idx;
    logic        frame_boundary;
    logic        in_dead;

    word_t       shadow_seg_q;
    word_t       shadow_seg_d;
    logic [3:0]  shadow_bri_q;
    logic [3:0]  shadow_bri_d;

    logic        pwm_on;
    logic        lit;
    seg_t        seg_raw;
    logic [3:0]  dig_onehot;

    seg_t        seg_out_q;
    seg_t        seg_out_d;
    logic [3:0]  dig_out_q;
    logic [3:0]  dig_out_d;

    seg7_slot_timer #(
        .DIGIT_TICKS    (DIGIT_TICKS),
        .DEADTIME_TICKS (DEADTIME_TICKS)
    ) u_timer (
        .clk              (clk),
        .reset            (reset),
        .pwm_phase_o      (pwm_phase),
        .dig_idx_o        (dig_idx),
        .frame_boundary_o (frame_boundary),
        .in_dead_o        (in_dead)
    );

    // Shadow next-state: capture the live word/brightness only at the frame boundary.
    always_comb begin
        shadow_seg_d = shadow_seg_q;
        shadow_bri_d = shadow_bri_q;
        if (frame_boundary) begin
            shadow_seg_d = seg_data;
            shadow_bri_d = brightness;
        end
    end

    // Shadow registers; cleared by reset so nothing shows before the first load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_seg_q <= '0;
            shadow_bri_q <= '0;
        end else begin
            shadow_seg_q <= shadow_seg_d;
            shadow_bri_q <= shadow_bri_d;
        end
    end

    // PWM gate and output decode. Brightness 15 is fully on inside the lit
    // window; otherwise the low 4 slot-counter bits form a 16-cycle PWM ramp.
    always_comb begin
        pwm_on     = (shadow_bri_q == 4'hF) || (pwm_phase < shadow_bri_q);
        lit        = !in_dead && pwm_on;
        seg_raw    = seg_slice(shadow_seg_q, dig_idx);
        dig_onehot = 4'b0001 << dig_idx;
        seg_out_d  = SEG_OFF;
        dig_out_d  = DIG_OFF;
        if (lit) begin
            seg_out_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
            dig_out_d = DIG_ACTIVE_LOW ? ~dig_onehot : dig_onehot;
        end
    end

    // Output registers; reset forces every line inactive immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_out_q <= SEG_OFF;
            dig_out_q <= DIG_OFF;
        end else begin
            seg_out_q <= seg_out_d;
            dig_out_q <= dig_out_d;
        end
    end

    // Frame pulse is a live decode of the counter state, held low during reset.
    always_comb begin
        seg_out     = seg_out_q;
        dig_out     = dig_out_q;
        frame_start = frame_boundary && !reset;
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGIT_TICKS=32, DEADTIME_TICKS=8,
// active-low segments and digits. Position p in a frame means p falling
// edges after the falling edge at which frame_start was seen; the outputs
// there reflect the counter state p-1 (slot=(p-1)%32, digit=(p-1)/32).
module tb_seg7_scan_driver;

    localparam int DT = 32;
    localparam int DD = 8;
    localparam int FRAME = 4 * DT;

    localparam logic [27:0] W_A  = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    localparam logic [27:0] W_B  = {7'h7F, 7'h6D, 7'h66, 7'h07};
    localparam logic [27:0] W_C  = {7'h00, 7'h00, 7'h00, 7'h6D};
    localparam logic [27:0] W_D  = {7'h00, 7'h00, 7'h00, 7'h66};
    localparam logic [27:0] W_T2 = {21'h0, 7'h3F};

    logic        clk;
    logic        reset;
    logic [27:0] seg_data;
    logic [3:0]  brightness;
    logic [6:0]  seg_out;
    logic [3:0]  dig_out;
    logic        frame_start;

    int total_cnt;
    int pass_cnt;

    typedef struct {
        logic [27:0] word;
        logic [3:0]  bri;
        int          pos;
        logic [3:0]  exp_dig;
        logic [6:0]  exp_seg;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    seg7_scan_driver #(
        .DIGIT_TICKS    (DT),
        .DEADTIME_TICKS (DD),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_data    (seg_data),
        .brightness  (brightness),
        .seg_out     (seg_out),
        .dig_out     (dig_out),
        .frame_start (frame_start)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the next falling edge on which frame_start is high (bounded).
    task automatic wait_frame(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
        end
        check({name, "_frame_sync"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int gap;
        int fs_cnt;
        int dark_cnt;
        int bad_seg;
        int lit_seen;
        logic [3:0] prev_dig;
        logic [6:0] prev_seg;

        total_cnt  = 0;
        pass_cnt   = 0;
        reset      = 1'b1;
        seg_data   = W_A;
        brightness = 4'hF;

        vecs[0]  = '{W_A,  4'hF, 1,   4'hF, 7'h7F};
        vecs[1]  = '{W_A,  4'hF, 8,   4'hF, 7'h7F};
        vecs[2]  = '{W_A,  4'hF, 9,   4'hE, 7'h40};
        vecs[3]  = '{W_A,  4'hF, 32,  4'hE, 7'h40};
        vecs[4]  = '{W_A,  4'hF, 33,  4'hF, 7'h7F};
        vecs[5]  = '{W_A,  4'hF, 41,  4'hD, 7'h79};
        vecs[6]  = '{W_A,  4'hF, 80,  4'hB, 7'h24};
        vecs[7]  = '{W_A,  4'hF, 127, 4'h7, 7'h30};
        vecs[8]  = '{W_A,  4'h4, 16,  4'hF, 7'h7F};
        vecs[9]  = '{W_A,  4'h4, 17,  4'hE, 7'h40};
        vecs[10] = '{W_A,  4'h4, 20,  4'hE, 7'h40};
        vecs[11] = '{W_A,  4'h4, 21,  4'hF, 7'h7F};
        vecs[12] = '{W_A,  4'h4, 12,  4'hF, 7'h7F};
        vecs[13] = '{W_A,  4'h4, 113, 4'h7, 7'h30};
        vecs[14] = '{W_A,  4'h1, 17,  4'hE, 7'h40};
        vecs[15] = '{W_A,  4'h1, 18,  4'hF, 7'h7F};
        vecs[16] = '{W_A,  4'h0, 17,  4'hF, 7'h7F};
        vecs[17] = '{W_T2, 4'hF, 41,  4'hD, 7'h7F};
        vecs[18] = '{W_T2, 4'hF, 9,   4'hE, 7'h40};

        // 1: outputs inactive while reset is held, then exact frame period.
        step(4);
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_dig", 32'(dig_out), 32'hF);
        check("rst_fs", 32'(frame_start), 32'd0);
        reset = 1'b0;
        #1;
        check("release_fs", 32'(frame_start), 32'd1);
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            fs_cnt = 0;
            for (int i = 0; i < 3 * FRAME; i++) begin
                @(negedge clk);
                gap++;
                if (frame_start) break;
            end
            check($sformatf("fs_period%0d", k), 32'(gap), 32'(FRAME));
        end

        // Table-driven vectors: load word/brightness, sync to a frame, sample at pos.
        for (int v = 0; v < NVEC; v++) begin
            seg_data   = vecs[v].word;
            brightness = vecs[v].bri;
            wait_frame($sformatf("vec%0d", v));
            step(vecs[v].pos);
            check($sformatf("vec%0d_dig", v), 32'(dig_out), 32'(vecs[v].exp_dig));
            check($sformatf("vec%0d_seg", v), 32'(seg_out), 32'(vecs[v].exp_seg));
        end

        // 2: over one full-brightness frame, 8 dark cycles per slot, dark means
        // segments off, and segments never change while a digit stays enabled.
        seg_data   = W_A;
        brightness = 4'hF;
        wait_frame("blank");
        wait_frame("blank2");
        dark_cnt = 0;
        bad_seg  = 0;
        fs_cnt   = 0;
        prev_dig = dig_out;
        prev_seg = seg_out;
        for (int p = 1; p <= FRAME; p++) begin
            @(negedge clk);
            if (dig_out == 4'hF) begin
                dark_cnt++;
                if (seg_out != 7'h7F) bad_seg++;
            end else if (prev_dig == dig_out && prev_seg != seg_out) begin
                bad_seg++;
            end
            if (frame_start) fs_cnt++;
            prev_dig = dig_out;
            prev_seg = seg_out;
        end
        check("blank_dark_cycles", 32'(dark_cnt), 32'(4 * DD));
        check("blank_seg_glitch", 32'(bad_seg), 32'd0);
        check("blank_fs_one", 32'(fs_cnt), 32'd1);

        // 4: write at frame cycle 40 is held off until the next frame.
        seg_data = W_A;
        wait_frame("mid");
        step(40);
        seg_data = W_B;
        step(1);
        check("mid_old_dig", 32'(dig_out), 32'hD);
        check("mid_old_seg", 32'(seg_out), 32'h79);
        step(40);
        check("mid_old_seg_d2", 32'(seg_out), 32'h24);
        wait_frame("mid_next");
        step(41);
        check("mid_new_dig", 32'(dig_out), 32'hD);
        check("mid_new_seg", 32'(seg_out), 32'h19);

        // Write exactly on the boundary is captured; one cycle later waits a frame.
        seg_data = W_A;
        wait_frame("edge");
        seg_data = W_C;
        step(1);
        seg_data = W_D;
        step(8);
        check("edge_on_seg", 32'(seg_out), 32'h12);
        wait_frame("edge_next");
        step(9);
        check("edge_late_seg", 32'(seg_out), 32'h19);

        // 5: asynchronous reset while digit 2 is lit, then restart at digit 0.
        seg_data = W_A;
        wait_frame("areset");
        step(80);
        check("areset_pre_dig", 32'(dig_out), 32'hB);
        #2;
        reset = 1'b1;
        #1;
        check("areset_dig", 32'(dig_out), 32'hF);
        check("areset_seg", 32'(seg_out), 32'h7F);
        check("areset_fs", 32'(frame_start), 32'd0);
        step(3);
        reset = 1'b0;
        #1;
        check("areset_release_fs", 32'(frame_start), 32'd1);
        step(9);
        check("areset_restart_dig", 32'(dig_out), 32'hE);
        check("areset_restart_seg", 32'(seg_out), 32'h40);

        // 6: brightness 0 keeps the display dark while frames keep pulsing.
        seg_data   = {28{1'b1}};
        brightness = 4'h0;
        wait_frame("dark");
        lit_seen = 0;
        fs_cnt   = 0;
        for (int p = 1; p <= 3 * FRAME; p++) begin
            @(negedge clk);
            if (dig_out != 4'hF) lit_seen++;
            if (frame_start) fs_cnt++;
        end
        check("dark_lit_cycles", 32'(lit_seen), 32'd0);
        check("dark_fs_count", 32'(fs_cnt), 32'd3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
